// File: rtl/regfile_scoreboard.sv
// Integer register file with NUM_RD registered read ports, one write port and a
// pending-write scoreboard; reads forward same-cycle writeback data.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_RD-1:0]      rd_en_i,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      busy_o,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [XLEN-1:0]        wr_data_i,
    input  logic                   issue_en_i,
    input  logic [AW-1:0]          issue_addr_i
);

    logic [DEPTH-1:0][XLEN-1:0] regs_q;
    logic [DEPTH-1:0]           busy_q;
    logic [DEPTH-1:0]           busy_d;
    logic [NUM_RD*XLEN-1:0]     rd_data_q;
    logic [NUM_RD*XLEN-1:0]     rd_data_d;
    logic                       wr_live;

    assign wr_live   = wr_en_i && (wr_addr_i != '0);
    assign rd_data_o = rd_data_q;

    // Read data is the register value after this edge's write, so a matching
    // writeback is forwarded instead of the stale array contents.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en_i[p]) begin
                if (rd_addr_i[p*AW +: AW] == '0)
                    rd_data_d[p*XLEN +: XLEN] = '0;
                else if (wr_live && (wr_addr_i == rd_addr_i[p*AW +: AW]))
                    rd_data_d[p*XLEN +: XLEN] = wr_data_i;
                else
                    rd_data_d[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
            end
        end
    end

    // Issue is applied after the clear so a same-address issue wins: the newer
    // producer is still outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_i)
            busy_d[wr_addr_i] = 1'b0;
        if (issue_en_i)
            busy_d[issue_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            busy_o[p] = busy_q[rd_addr_i[p*AW +: AW]]
                        && !(wr_en_i && (wr_addr_i == rd_addr_i[p*AW +: AW]));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q    <= '0;
            busy_q    <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_live)
                regs_q[wr_addr_i] <= wr_data_i;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against an array-based
// reference model of the architectural registers and pending-write set.
module tb_regfile_scoreboard;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NUM_RD-1:0]      rd_en_i;
    logic [NUM_RD*AW-1:0]   rd_addr_i;
    logic [NUM_RD*XLEN-1:0] rd_data_o;
    logic [NUM_RD-1:0]      busy_o;
    logic                   wr_en_i;
    logic [AW-1:0]          wr_addr_i;
    logic [XLEN-1:0]        wr_data_i;
    logic                   issue_en_i;
    logic [AW-1:0]          issue_addr_i;

    int checks = 0;
    int passes = 0;

    logic [XLEN-1:0] m_regs [DEPTH];
    bit              m_busy [DEPTH];
    logic [XLEN-1:0] m_rd   [NUM_RD];

    always #5 clk_i = ~clk_i;

    regfile_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .busy_o       (busy_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] rdp(int p);
        return rd_data_o[p*XLEN +: XLEN];
    endfunction

    function automatic logic [AW-1:0] ra(int p);
        return rd_addr_i[p*AW +: AW];
    endfunction

    task automatic idle();
        rd_en_i      = '0;
        rd_addr_i    = '0;
        wr_en_i      = 1'b0;
        wr_addr_i    = '0;
        wr_data_i    = '0;
        issue_en_i   = 1'b0;
        issue_addr_i = '0;
    endtask

    task automatic set_rd(int p, logic [AW-1:0] a);
        rd_en_i[p]            = 1'b1;
        rd_addr_i[p*AW +: AW] = a;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;
    endtask

    task automatic check_busy(string tag);
        for (int p = 0; p < NUM_RD; p++)
            check(tag, busy_o[p], m_busy[ra(p)] && !(wr_en_i && wr_addr_i == ra(p)));
    endtask

    // One clock with the currently driven inputs: checks busy before the edge,
    // advances the model, then checks read data after the edge.
    task automatic step(string tag);
        #1;
        check_busy({tag, "_busy"});
        @(posedge clk_i);
        if (wr_en_i && wr_addr_i != '0) m_regs[wr_addr_i] = wr_data_i;
        for (int p = 0; p < NUM_RD; p++)
            if (rd_en_i[p]) m_rd[p] = m_regs[ra(p)];
        if (wr_en_i) m_busy[wr_addr_i] = 1'b0;
        if (issue_en_i && issue_addr_i != '0) m_busy[issue_addr_i] = 1'b1;
        #1;
        for (int p = 0; p < NUM_RD; p++) check({tag, "_rd"}, rdp(p), m_rd[p]);
    endtask

    task automatic random_traffic(int n);
        for (int i = 0; i < n; i++) begin
            idle();
            for (int p = 0; p < NUM_RD; p++) begin
                rd_en_i[p] = ($urandom_range(0, 3) != 0);
                rd_addr_i[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            wr_en_i      = $urandom_range(0, 1) == 1;
            wr_addr_i    = AW'($urandom_range(0, 7));
            wr_data_i    = $urandom;
            issue_en_i   = $urandom_range(0, 2) == 0;
            issue_addr_i = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                rd_addr_i[AW +: AW] = AW'($urandom_range(0, DEPTH-1));
                wr_addr_i           = AW'($urandom_range(0, DEPTH-1));
            end
            step("rand");
        end
    endtask

    logic [XLEN-1:0] held;

    initial begin
        idle();
        model_reset();
        rst_ni = 1'b0;
        #12;
        check("reset_rd0", rdp(0), 0);
        check("reset_rd1", rdp(1), 0);
        check("reset_busy", busy_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // T2 write then read on both ports
        idle(); wr_en_i = 1; wr_addr_i = 5; wr_data_i = 32'hDEADBEEF;
        step("t2_wr");
        idle(); set_rd(0, 5); set_rd(1, 5);
        step("t2_rd");
        check("t2_p0", rdp(0), 32'hDEADBEEF);
        check("t2_p1", rdp(1), 32'hDEADBEEF);

        // T3 same-cycle forward
        idle(); wr_en_i = 1; wr_addr_i = 7; wr_data_i = 32'h1234;
        set_rd(1, 7); set_rd(0, 6);
        step("t3");
        check("t3_fwd", rdp(1), 32'h1234);
        check("t3_r6", rdp(0), 0);

        // T4 register zero
        idle(); wr_en_i = 1; wr_addr_i = 0; wr_data_i = 32'hFFFFFFFF;
        issue_en_i = 1; issue_addr_i = 0;
        step("t4_wr");
        idle(); set_rd(0, 0); set_rd(1, 0);
        #1;
        check("t4_busy", busy_o, 0);
        step("t4_rd");
        check("t4_r0", rdp(0), 0);

        // T5 scoreboard set, hold, clear
        idle(); issue_en_i = 1; issue_addr_i = 3;
        step("t5_iss");
        idle(); set_rd(0, 3);
        #1;
        check("t5_busy", busy_o[0], 1);
        step("t5_hold");
        #1;
        check("t5_busy_hold", busy_o[0], 1);
        wr_en_i = 1; wr_addr_i = 3; wr_data_i = 32'hA5A5;
        #1;
        check("t5_busy_wr", busy_o[0], 0);
        step("t5_wr");
        check("t5_fwd", rdp(0), 32'hA5A5);
        idle(); set_rd(0, 3);
        #1;
        check("t5_busy_after", busy_o[0], 0);
        step("t5_after");

        // T6 issue and writeback collide on r9
        idle(); issue_en_i = 1; issue_addr_i = 9;
        wr_en_i = 1; wr_addr_i = 9; wr_data_i = 32'h99;
        step("t6_coll");
        idle(); set_rd(1, 9);
        #1;
        check("t6_busy", busy_o[1], 1);
        step("t6_rd");
        check("t6_rd9", rdp(1), 32'h99);
        idle(); wr_en_i = 1; wr_addr_i = 9; wr_data_i = 32'h77;
        step("t6_wr");
        held = rdp(1);
        idle(); rd_addr_i[AW +: AW] = 9;
        #1;
        check("t6_busy_clr", busy_o[1], 0);
        step("t6_hold");
        check("t6_held", rdp(1), held);

        random_traffic(400);

        // T1 asynchronous reset mid-cycle with traffic on the inputs
        idle(); set_rd(0, 5); set_rd(1, 7);
        wr_en_i = 1; wr_addr_i = 5; wr_data_i = 32'hCAFE;
        issue_en_i = 1; issue_addr_i = 5;
        #2;
        rst_ni = 1'b0;
        #1;
        check("t1_rd0", rdp(0), 0);
        check("t1_rd1", rdp(1), 0);
        check("t1_busy", busy_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        check("t1_hold", rd_data_o, 0);
        #3;
        rst_ni = 1'b1;
        for (int a = 0; a < DEPTH; a += 2) begin
            idle(); set_rd(0, AW'(a)); set_rd(1, AW'(a + 1));
            step("t1_clear");
            check("t1_zero", rd_data_o, 0);
        end

        random_traffic(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
